// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling-message engine.
// Contents: FSM state enum, mode encodings, default blank symbol code
// and the width helper used to size the window position.
package scroll_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } scroll_state_e;

  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  localparam logic [3:0] DEFAULT_BLANK = 4'hF;

  // Bits needed to index n positions; never less than one bit.
  function automatic int unsigned pos_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scroll_window_sel.sv
// Combinational window selector: maps the virtual ring (message followed
// by blank gap positions) onto DIGITS display slots starting at pos_i.
// Ports:
//   msg_i      flat message buffer, symbol 0 in the MSB slice
//   pos_i      window start index into the ring
//   ring_len_i current ring length L (> pos_i)
//   digits_o   window, leftmost digit in the MSB slice
module scroll_window_sel
  import scroll_pkg::*;
#(
  parameter int unsigned       MSG_LEN = 8,
  parameter int unsigned       DIGITS  = 4,
  parameter int unsigned       SYM_W   = 4,
  parameter int unsigned       PW      = 4,
  parameter int unsigned       IW      = 5,
  parameter logic [SYM_W-1:0]  BLANK   = '1
) (
  input  logic [MSG_LEN*SYM_W-1:0] msg_i,
  input  logic [PW-1:0]            pos_i,
  input  logic [IW-1:0]            ring_len_i,
  output logic [DIGITS*SYM_W-1:0]  digits_o
);

  always_comb begin : sel
    logic [IW-1:0]    idx;
    logic [SYM_W-1:0] sym;
    digits_o = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      // pos < L and k < DIGITS <= L, so one conditional subtract is a full mod L.
      idx = IW'(pos_i) + IW'(k);
      if (idx >= ring_len_i) idx = idx - ring_len_i;
      sym = BLANK;
      for (int unsigned i = 0; i < MSG_LEN; i++) begin
        if (idx == IW'(i)) sym = msg_i[(MSG_LEN-1-i)*SYM_W +: SYM_W];
      end
      digits_o[(DIGITS-1-k)*SYM_W +: SYM_W] = sym;
    end
  end

endmodule

// File: rtl/scroll_engine_param.sv
// Scrolling-message engine for multi-digit 7-segment displays.
// Advances a DIGITS-wide window over a loaded message once per
// slow_clock_1Hz edge, either wrapping (with GAP blanks after the message)
// or bouncing between the ends with a HOLD-tick dwell.
// Ports:
//   slow_clock_1Hz  scroll clock
//   reset           asynchronous, active-high
//   load            capture msg_in, restart at pos 0 (beats enable)
//   msg_in          message, symbol 0 in the MSB slice
//   enable          1 = advance, 0 = freeze
//   dir             wrap only: 0 = left (pos+1), 1 = right (pos-1)
//   mode            0 = wrap, 1 = bounce
//   digits_out      window, leftmost digit in the MSB slice
//   pos             window start index
//   end_pulse       one-tick strobe on cycle/end events
module scroll_engine_param
  import scroll_pkg::*;
#(
  parameter int unsigned      MSG_LEN = 8,
  parameter int unsigned      DIGITS  = 4,
  parameter int unsigned      SYM_W   = 4,
  parameter int unsigned      GAP     = 1,
  parameter logic [SYM_W-1:0] BLANK   = SYM_W'(DEFAULT_BLANK),
  parameter int unsigned      HOLD    = 2
) (
  input  logic                                   slow_clock_1Hz,
  input  logic                                   reset,
  input  logic                                   load,
  input  logic [MSG_LEN*SYM_W-1:0]               msg_in,
  input  logic                                   enable,
  input  logic                                   dir,
  input  logic                                   mode,
  output logic [DIGITS*SYM_W-1:0]                digits_out,
  output logic [pos_width(MSG_LEN+GAP)-1:0]      pos,
  output logic                                   end_pulse
);

  localparam int unsigned PW    = pos_width(MSG_LEN + GAP);
  localparam int unsigned IW    = pos_width(2 * (MSG_LEN + GAP));
  localparam int unsigned HW    = pos_width(HOLD + 1);
  localparam int unsigned P_MAX = MSG_LEN - DIGITS;

  localparam logic [PW-1:0] P_MAX_P = PW'(P_MAX);
  localparam logic [PW-1:0] L_LAST  = PW'(MSG_LEN + GAP - 1);
  localparam logic [HW-1:0] HOLD_C  = HW'(HOLD);

  if (!(MSG_LEN >= DIGITS && DIGITS >= 1)) begin : g_param_check
    $error("scroll_engine_param: require MSG_LEN >= DIGITS >= 1");
  end

  logic [MSG_LEN*SYM_W-1:0] msg_q, msg_d;
  logic [PW-1:0]            pos_q, pos_d;
  scroll_state_e            state_q, state_d;
  logic                     up_q, up_d;
  logic [HW-1:0]            cnt_q, cnt_d;
  logic                     pulse_q, pulse_d;
  logic                     mode_q, mode_d;
  logic [IW-1:0]            ring_len;

  always_ff @(posedge slow_clock_1Hz or posedge reset) begin
    if (reset) begin
      msg_q   <= {MSG_LEN{BLANK}};
      pos_q   <= '0;
      state_q <= ST_RUN;
      up_q    <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      mode_q  <= MODE_WRAP;
    end else begin
      msg_q   <= msg_d;
      pos_q   <= pos_d;
      state_q <= state_d;
      up_q    <= up_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    msg_d   = msg_q;
    pos_d   = pos_q;
    state_d = state_q;
    up_d    = up_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    mode_d  = mode_q;
    if (load) begin
      msg_d   = msg_in;
      pos_d   = '0;
      state_d = ST_RUN;
      up_d    = 1'b1;
      cnt_d   = '0;
      mode_d  = mode;
    end else if (enable) begin
      mode_d = mode;
      if (mode != mode_q) begin
        // A mode change edge only re-normalises state; stepping resumes next edge.
        state_d = ST_RUN;
        if (mode == MODE_BOUNCE) begin
          up_d = 1'b1;
          if (pos_q > P_MAX_P) pos_d = '0;
        end
      end else if (mode == MODE_WRAP) begin
        state_d = ST_RUN;
        if (!dir) begin
          if (pos_q == L_LAST) begin
            pos_d   = '0;
            pulse_d = 1'b1;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else begin
          if (pos_q == '0) begin
            pos_d   = L_LAST;
            pulse_d = 1'b1;
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
      end else if (P_MAX != 0) begin
        unique case (state_q)
          ST_RUN: begin
            // Clamped steps keep pos in range if bounce was entered at an end.
            if (up_q) begin
              if (pos_q < P_MAX_P) pos_d = pos_q + PW'(1);
              if (pos_d == P_MAX_P) begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_C;
                pulse_d = 1'b1;
              end
            end else begin
              if (pos_q != '0) pos_d = pos_q - PW'(1);
              if (pos_d == '0) begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_C;
                pulse_d = 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (cnt_q == '0) begin
              up_d    = !up_q;
              state_d = ST_RUN;
            end else begin
              cnt_d = cnt_q - HW'(1);
            end
          end
          default: state_d = ST_RUN;
        endcase
      end
    end
  end

  assign ring_len = (mode_q == MODE_BOUNCE) ? IW'(MSG_LEN) : IW'(MSG_LEN + GAP);

  scroll_window_sel #(
    .MSG_LEN (MSG_LEN),
    .DIGITS  (DIGITS),
    .SYM_W   (SYM_W),
    .PW      (PW),
    .IW      (IW),
    .BLANK   (BLANK)
  ) u_window_sel (
    .msg_i      (msg_q),
    .pos_i      (pos_q),
    .ring_len_i (ring_len),
    .digits_o   (digits_out)
  );

  assign pos       = pos_q;
  assign end_pulse = pulse_q;

endmodule

// File: tb/tb_scroll_engine_param.sv
// Directed bench for scroll_engine_param at default parameters
// (MSG_LEN=8, DIGITS=4, SYM_W=4, GAP=1, BLANK=F, HOLD=2).
module tb_scroll_engine_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] msg_in;
  logic        enable;
  logic        dir;
  logic        mode;
  logic [15:0] digits_out;
  logic [3:0]  pos;
  logic        end_pulse;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  scroll_engine_param #(
    .MSG_LEN (8),
    .DIGITS  (4),
    .SYM_W   (4),
    .GAP     (1),
    .BLANK   (4'hF),
    .HOLD    (2)
  ) dut (
    .slow_clock_1Hz (clk),
    .reset          (reset),
    .load           (load),
    .msg_in         (msg_in),
    .enable         (enable),
    .dir            (dir),
    .mode           (mode),
    .digits_out     (digits_out),
    .pos            (pos),
    .end_pulse      (end_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] m);
    load   = 1'b1;
    msg_in = m;
    tick();
    load   = 1'b0;
  endtask

  // Wrap-left windows after ticks 1..9 from pos 0 with message 1..8.
  logic [15:0] wrap_win [9] = '{16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h678F,
                                16'h78F1, 16'h8F12, 16'hF123, 16'h1234};
  // Bounce positions after ticks 1..15 from pos 0, and where end_pulse rises.
  logic [3:0]  bnc_pos [15] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd3,
                                4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
  logic        bnc_pul [15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    msg_in = '0;
    enable = 1'b0;
    dir    = 1'b0;
    mode   = 1'b0;
    #2;
    check("reset_digits", 32'(digits_out), 32'hFFFF);
    check("reset_pos", 32'(pos), 0);
    check("reset_pulse", 32'(end_pulse), 0);
    #10;
    reset = 1'b0;

    // Wrap left through a full cycle.
    enable = 1'b1;
    do_load(32'h12345678);
    check("load_win", 32'(digits_out), 32'h1234);
    check("load_pos", 32'(pos), 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("wrapL_win%0d", i + 1), 32'(digits_out), 32'(wrap_win[i]));
      check($sformatf("wrapL_pos%0d", i + 1), 32'(pos), 32'((i + 1) % 9));
      check($sformatf("wrapL_pulse%0d", i + 1), 32'(end_pulse), (i == 8) ? 1 : 0);
    end

    // Wrap right from pos 0.
    do_load(32'h12345678);
    dir = 1'b1;
    tick();
    check("wrapR_win1", 32'(digits_out), 32'hF123);
    check("wrapR_pos1", 32'(pos), 8);
    check("wrapR_pulse1", 32'(end_pulse), 1);
    tick();
    check("wrapR_win2", 32'(digits_out), 32'h8F12);
    check("wrapR_pulse2", 32'(end_pulse), 0);

    // Freeze at pos 5.
    dir = 1'b0;
    do_load(32'h12345678);
    repeat (5) tick();
    check("pre_freeze_pos", 32'(pos), 5);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("freeze_pos%0d", i), 32'(pos), 5);
      check($sformatf("freeze_win%0d", i), 32'(digits_out), 32'h678F);
      check($sformatf("freeze_pulse%0d", i), 32'(end_pulse), 0);
    end
    enable = 1'b1;
    tick();
    check("unfreeze_win", 32'(digits_out), 32'h78F1);
    tick();
    check("pre_switch_pos", 32'(pos), 7);

    // Wrap at pos 7 into bounce: pos clamps to 0, then steps.
    mode = 1'b1;
    tick();
    check("switch_pos", 32'(pos), 0);
    check("switch_win", 32'(digits_out), 32'h1234);
    check("switch_pulse", 32'(end_pulse), 0);
    tick();
    check("switch_step_pos", 32'(pos), 1);
    check("switch_step_win", 32'(digits_out), 32'h2345);

    // Bounce with end hold.
    do_load(32'h12345678);
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("bounce_pos%0d", i + 1), 32'(pos), 32'(bnc_pos[i]));
      check($sformatf("bounce_pulse%0d", i + 1), 32'(end_pulse), 32'(bnc_pul[i]));
      if (i == 3) check("bounce_win_end", 32'(digits_out), 32'h5678);
    end

    // Load while holding at pos 4.
    do_load(32'h12345678);
    repeat (5) tick();
    check("hold_pos", 32'(pos), 4);
    do_load(32'h99990000);
    check("reload_pos", 32'(pos), 0);
    check("reload_win", 32'(digits_out), 32'h9999);
    check("reload_pulse", 32'(end_pulse), 0);
    tick();
    check("reload_run_pos", 32'(pos), 1);
    check("reload_run_win", 32'(digits_out), 32'h9990);

    // Asynchronous reset between edges.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_win", 32'(digits_out), 32'hFFFF);
    check("async_rst_pos", 32'(pos), 0);
    #5;
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
